keyv_delay_cfg: RTL



---
 rtl/keyv_delay_cfg_pkg.sv | 25 ++
 rtl/keyv_delay_cfg_therm.sv | 21 ++
 rtl/keyv_delay_cfg.sv | 118 +++++++++++
 3 files changed

// File: rtl/keyv_delay_cfg_pkg.sv
// Shared keyring definitions: delay-line length, stage and controller-state
// enums, and the thermometer-code helper used for reset defaults.
package keyv_delay_cfg_pkg;

    localparam int KEYRING_L = 30;

    typedef logic [KEYRING_L-1:0] t_keyring_delay;

    typedef enum logic [2:0] {F, D, R, E, M, W, MU} t_delay_stage;

    typedef enum logic [2:0] {IDLE, REQ, APPLY, SETTLE, RELEASE} t_cfg_state;

    // Ones fill from the MSB downward; values beyond the line length saturate.
    function automatic t_keyring_delay to_thermometer(input int val);
        t_keyring_delay t;
        int v;
        v = (val > KEYRING_L) ? KEYRING_L : val;
        t = '0;
        for (int i = 0; i < KEYRING_L; i++) begin
            if (i >= KEYRING_L - v) t[i] = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/keyv_delay_cfg_therm.sv
// Combinational clamp and thermometer encoder: VAL_W-bit delay count to a
// KEYRING_L-bit code with the ones packed against the MSB.
module keyv_therm_enc #(
    parameter int KEYRING_L = 30,
    parameter int VAL_W     = 5
) (
    input  logic [VAL_W-1:0]     val,
    output logic [KEYRING_L-1:0] therm
);

    int clamped;

    always_comb begin
        clamped = (int'(val) > KEYRING_L) ? KEYRING_L : int'(val);
        therm   = '0;
        for (int i = 0; i < KEYRING_L; i++) begin
            if (i >= KEYRING_L - clamped) therm[i] = 1'b1;
        end
    end

endmodule

// File: rtl/keyv_delay_cfg.sv
// Run-time delay-line configuration controller: quiesces the core through a
// hold handshake, then rewrites one stage's thermometer-coded delay.
module keyv_delay_cfg #(
    parameter int KEYRING_L     = keyv_delay_cfg_pkg::KEYRING_L,
    parameter int N_STAGES      = 7,
    parameter int VAL_W         = 5,
    parameter logic [N_STAGES*KEYRING_L-1:0] RESET_DELAYS =
        {N_STAGES{keyv_delay_cfg_pkg::to_thermometer(1)}},
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [2:0]                      cfg_stage,
    input  logic [VAL_W-1:0]                cfg_val,
    output logic                            cfg_err,
    output logic                            busy,
    output logic                            hold_req,
    input  logic                            hold_ack,
    output logic [N_STAGES*KEYRING_L-1:0]   delay_o
);

    import keyv_delay_cfg_pkg::*;

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [ST_W-1:0] SETTLE_LOAD = ST_W'(SETTLE_CYCLES - 1);

    t_cfg_state             state_q, state_n;
    logic [2:0]             stage_q;
    logic [VAL_W-1:0]       val_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic [ST_W-1:0]        settle_q;
    logic                   accept;
    logic                   err_n;
    logic [KEYRING_L-1:0]   therm;

    keyv_therm_enc #(
        .KEYRING_L (KEYRING_L),
        .VAL_W     (VAL_W)
    ) u_therm (
        .val   (val_q),
        .therm (therm)
    );

    always_comb begin
        state_n = state_q;
        err_n   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    accept = 1'b1;
                    if (int'(cfg_stage) >= N_STAGES) err_n = 1'b1;
                    else                             state_n = REQ;
                end
            end
            REQ: begin
                if (hold_ack) begin
                    state_n = APPLY;
                end else if (to_cnt_q == TO_LAST) begin
                    state_n = RELEASE;
                    err_n   = 1'b1;
                end
            end
            APPLY:   state_n = SETTLE;
            SETTLE:  if (settle_q == '0) state_n = RELEASE;
            RELEASE: if (!hold_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            val_q     <= '0;
            to_cnt_q  <= '0;
            settle_q  <= '0;
            delay_o   <= RESET_DELAYS;
            hold_req  <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_n;
            hold_req  <= (state_n == REQ) || (state_n == APPLY) || (state_n == SETTLE);
            cfg_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
            cfg_err   <= err_n;

            if (accept) begin
                stage_q <= cfg_stage;
                val_q   <= cfg_val;
            end

            if (state_q == REQ) to_cnt_q <= to_cnt_q + TO_W'(1);
            else                to_cnt_q <= '0;

            // Loading one less than the settle length keeps SETTLE at exactly
            // SETTLE_CYCLES cycles, since the zero count is itself a cycle.
            if (state_q == APPLY)       settle_q <= SETTLE_LOAD;
            else if (state_q == SETTLE) settle_q <= settle_q - ST_W'(1);

            if (state_q == APPLY) begin
                for (int i = 0; i < N_STAGES; i++) begin
                    if (stage_q == 3'(i)) delay_o[i*KEYRING_L +: KEYRING_L] <= therm;
                end
            end
        end
    end

endmodule
